hazard_scoreboard: RTL and testbench

- Parametrised successor to the 5-stage pipeline's combinational hazard unit.
- Keeps a per-register pending-write scoreboard with latency countdowns. This lets it stall correctly for variable-latency producers: ALU, load, and a multi-cycle long unit such as mul/div.
- Sits at ID: it takes decoded source and destination fields and drives PC/IF-ID write enables and the ID/EX bubble mux.
- Adds forwarding-aware mode, WAW and long-unit structural stalls, and a stall performance counter.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/sb_entry.sv | 45 ++++
 rtl/hazard_scoreboard.sv | 110 +++++++++++
 tb/tb_hazard_scoreboard.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register index width, latency code width, long-unit code.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  localparam int PIPE_REG_AW = 5;
  localparam int PIPE_LAT_W  = 3;

  // All-ones latency code marks a long-unit producer that is pending until writeback.
  localparam logic [PIPE_LAT_W-1:0] PIPE_LONG = '1;

  typedef logic [PIPE_REG_AW-1:0] reg_idx_t;

endpackage

// File: rtl/sb_entry.sv
// One register's scoreboard entry: latency down-counter plus long-unit pending flag.
// Latency: load/clear visible on pend the cycle after the edge that captures them.
// Backpressure: none; the owner decides when to load, the entry always accepts.
module sb_entry
  import pipe_pkg::*;
#(
  parameter int LAT_W = PIPE_LAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             load_long,
  input  logic [LAT_W-1:0] load_cnt,
  input  logic             wb_clr,
  output logic             pend
);

  logic [LAT_W-1:0] cnt;
  logic             long_q;

  // Counter: a new issue overrides the free-running decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_long ? '0 : load_cnt;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Long flag: set by a long issue, cleared only by a matching writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_q <= 1'b0;
    end else if (load && load_long) begin
      long_q <= 1'b1;
    end else if (wb_clr) begin
      long_q <= 1'b0;
    end
  end

  assign pend = (cnt != '0) | long_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register pending-write scoreboard driving stall/bubble controls.
// Latency: stall is combinational from registered state; scoreboard updates on the next edge.
// Backpressure: stall deasserts pc_write/if_id_write and injects a bubble into ID/EX.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = PIPE_REG_AW,
  parameter int LAT_W    = PIPE_LAT_W,
  parameter int FWD_EN   = 1,
  parameter int WB_LAT   = 3,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic                flush,
  input  logic [REG_AW-1:0]   rs1,
  input  logic [REG_AW-1:0]   rs2,
  input  logic                rs1_used,
  input  logic                rs2_used,
  input  logic [REG_AW-1:0]   rd,
  input  logic                reg_write,
  input  logic [LAT_W-1:0]    lat,
  input  logic                wb_valid,
  input  logic [REG_AW-1:0]   wb_rd,
  output logic                pc_write,
  output logic                if_id_write,
  output logic                control_mux,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [CNT_W-1:0]    stall_count
);

  localparam logic [LAT_W-1:0] LONG = '1;

  logic                   lat_long;
  logic                   long_busy;
  logic [NUM_REGS-1:0]    pend_vec;
  logic [2**REG_AW-1:0]   pend_all;
  logic                   raw_haz;
  logic                   waw_haz;
  logic                   struct_haz;
  logic                   stall_int;
  logic                   issue;
  logic [LAT_W-1:0]       load_cnt;

  assign lat_long = (lat == LONG);

  // x0 never has a pending write.
  assign pend_vec[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NUM_REGS; r++) begin : g_entry
      sb_entry #(.LAT_W(LAT_W)) u_entry (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (issue & reg_write & (rd == REG_AW'(r))),
        .load_long (lat_long),
        .load_cnt  (load_cnt),
        .wb_clr    (wb_valid & (wb_rd == REG_AW'(r))),
        .pend      (pend_vec[r])
      );
    end
  endgenerate

  // Widen to the full index space so out-of-range indices read as not pending.
  always_comb begin
    pend_all                = '0;
    pend_all[NUM_REGS-1:0]  = pend_vec;
  end

  assign raw_haz    = (rs1_used & pend_all[rs1]) | (rs2_used & pend_all[rs2]);
  assign waw_haz    = reg_write & (rd != '0) & pend_all[rd];
  assign struct_haz = lat_long & long_busy;

  assign stall_int = issue_valid & ~flush & (raw_haz | waw_haz | struct_haz);
  assign issue     = issue_valid & ~flush & ~stall_int;

  // Without forwarding every short producer is visible only after the fixed writeback delay.
  assign load_cnt = (FWD_EN != 0) ? lat : LAT_W'(WB_LAT);

  assign stall       = stall_int;
  assign control_mux = stall_int;
  assign pc_write    = ~stall_int;
  assign if_id_write = ~stall_int;
  assign busy_mask   = pend_vec;

  // Long unit occupancy: any writeback frees it; a new long issue takes it the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_busy <= 1'b0;
    end else if (issue && lat_long) begin
      long_busy <= 1'b1;
    end else if (wb_valid) begin
      long_busy <= 1'b0;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall_int && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding, fixed-latency, long-unit, x0, flush, reset.
// Three instances share stimulus: FWD_EN=1, FWD_EN=0 (WB_LAT=3), and a 2-bit stall counter.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, flush;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic        rs1_used, rs2_used, reg_write, wb_valid;
  logic [2:0]  lat;

  logic        pc_write1, if_id_write1, control_mux1, stall1;
  logic [31:0] busy_mask1, stall_count1;
  logic        pc_write0, if_id_write0, control_mux0, stall0;
  logic [31:0] busy_mask0, stall_count0;
  logic        pc_write2, if_id_write2, control_mux2, stall2;
  logic [31:0] busy_mask2;
  logic [1:0]  stall_count2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.FWD_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .flush(flush),
    .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd(rd), .reg_write(reg_write), .lat(lat), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .pc_write(pc_write1), .if_id_write(if_id_write1), .control_mux(control_mux1),
    .stall(stall1), .busy_mask(busy_mask1), .stall_count(stall_count1));

  hazard_scoreboard #(.FWD_EN(0), .WB_LAT(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .flush(flush),
    .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd(rd), .reg_write(reg_write), .lat(lat), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .pc_write(pc_write0), .if_id_write(if_id_write0), .control_mux(control_mux0),
    .stall(stall0), .busy_mask(busy_mask0), .stall_count(stall_count0));

  hazard_scoreboard #(.FWD_EN(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .flush(flush),
    .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd(rd), .reg_write(reg_write), .lat(lat), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .pc_write(pc_write2), .if_id_write(if_id_write2), .control_mux(control_mux2),
    .stall(stall2), .busy_mask(busy_mask2), .stall_count(stall_count2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic iv, input logic [4:0] a1, input logic u1,
                        input logic [4:0] a2, input logic u2, input logic [4:0] d,
                        input logic rw, input logic [2:0] l);
    issue_valid = iv; rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2;
    rd = d; reg_write = rw; lat = l;
  endtask

  task automatic idle();
    set_op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
    flush = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #2;
    tests++; if (pc_write1 !== 1'b1) begin fails++; $display("FAIL reset_pc_write got %b exp 1", pc_write1); end
    tests++; if (if_id_write1 !== 1'b1) begin fails++; $display("FAIL reset_if_id_write got %b exp 1", if_id_write1); end
    tests++; if (control_mux1 !== 1'b0) begin fails++; $display("FAIL reset_control_mux got %b exp 0", control_mux1); end
    tests++; if (stall1 !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", stall1); end
    tests++; if (busy_mask1 !== 32'h0) begin fails++; $display("FAIL reset_busy_mask got %h exp 0", busy_mask1); end
    tests++; if (stall_count1 !== 32'd0) begin fails++; $display("FAIL reset_stall_count got %0d exp 0", stall_count1); end
    rst_n = 1'b1;
    tick();
  endtask

  // lw x5 (lat 2) then add x6,x5,x1: two stall cycles, then issue.
  task automatic test_load_use();
    do_reset();
    tick();
    set_op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd2);
    #1;
    tests++; if (stall1 !== 1'b0) begin fails++; $display("FAIL lw_issue_stall got %b exp 0", stall1); end
    tick();
    tests++; if (busy_mask1 !== 32'h20) begin fails++; $display("FAIL lw_busy got %h exp 00000020", busy_mask1); end
    set_op(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 3'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++; if (stall1 !== 1'b1) begin fails++; $display("FAIL load_use_stall[%0d] got %b exp 1", i, stall1); end
      tests++; if (control_mux1 !== 1'b1) begin fails++; $display("FAIL load_use_bubble[%0d] got %b exp 1", i, control_mux1); end
      tests++; if (pc_write1 !== 1'b0) begin fails++; $display("FAIL load_use_pc_write[%0d] got %b exp 0", i, pc_write1); end
      tick();
    end
    tests++; if (stall1 !== 1'b0) begin fails++; $display("FAIL load_use_release got %b exp 0", stall1); end
    tests++; if (stall_count1 !== 32'd2) begin fails++; $display("FAIL load_use_count got %0d exp 2", stall_count1); end
    tick();
    tests++; if (busy_mask1 !== 32'h0) begin fails++; $display("FAIL load_use_busy_after got %h exp 0", busy_mask1); end
    idle();
  endtask

  // ALU x7 with lat 0 forwards immediately; FWD_EN=0 instance waits WB_LAT instead.
  task automatic test_alu_forward();
    do_reset();
    set_op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd0);
    tick();
    tests++; if (busy_mask1[7] !== 1'b0) begin fails++; $display("FAIL alu_busy7 got %b exp 0", busy_mask1[7]); end
    tests++; if (busy_mask0 !== 32'h80) begin fails++; $display("FAIL nofwd_busy got %h exp 00000080", busy_mask0); end
    set_op(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0, 3'd0);
    #1;
    tests++; if (stall1 !== 1'b0) begin fails++; $display("FAIL alu_consumer_stall got %b exp 0", stall1); end
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (stall0 !== 1'b1) begin fails++; $display("FAIL nofwd_stall[%0d] got %b exp 1", i, stall0); end
      tick();
    end
    tests++; if (stall0 !== 1'b0) begin fails++; $display("FAIL nofwd_release got %b exp 0", stall0); end
    tests++; if (stall_count0 !== 32'd3) begin fails++; $display("FAIL nofwd_count got %0d exp 3", stall_count0); end
    idle();
  endtask

  // Long div to x9: RAW, STRUCT and WAW stalls until writeback, then release.
  task automatic test_long_unit();
    do_reset();
    set_op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd7);
    tick();
    tests++; if (busy_mask1 !== 32'h200) begin fails++; $display("FAIL long_busy9 got %h exp 00000200", busy_mask1); end
    set_op(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 3'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (stall1 !== 1'b1) begin fails++; $display("FAIL long_raw_stall[%0d] got %b exp 1", i, stall1); end
      tick();
    end
    set_op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 3'd7);
    #1;
    tests++; if (stall1 !== 1'b1) begin fails++; $display("FAIL long_struct_stall got %b exp 1", stall1); end
    set_op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd1);
    #1;
    tests++; if (stall1 !== 1'b1) begin fails++; $display("FAIL long_waw_stall got %b exp 1", stall1); end
    set_op(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 3'd0);
    wb_valid = 1'b1; wb_rd = 5'd9;
    #1;
    tests++; if (stall1 !== 1'b1) begin fails++; $display("FAIL long_wb_no_bypass got %b exp 1", stall1); end
    tick();
    wb_valid = 1'b0;
    #1;
    tests++; if (stall1 !== 1'b0) begin fails++; $display("FAIL long_release got %b exp 0", stall1); end
    tests++; if (busy_mask1 !== 32'h0) begin fails++; $display("FAIL long_busy_after_wb got %h exp 0", busy_mask1); end
    tests++; if (stall_count1 !== 32'd4) begin fails++; $display("FAIL long_count got %0d exp 4", stall_count1); end
    tests++; if (stall_count2 !== 2'd3) begin fails++; $display("FAIL count_saturate got %0d exp 3", stall_count2); end
    tick();
    set_op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 3'd7);
    #1;
    tests++; if (stall1 !== 1'b0) begin fails++; $display("FAIL long_second_issue got %b exp 0", stall1); end
    tick();
    idle();
    wb_valid = 1'b1; wb_rd = 5'd11;
    tick();
    wb_valid = 1'b0;
    set_op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 3'd7);
    #1;
    tests++; if (stall1 !== 1'b0) begin fails++; $display("FAIL stray_wb_frees_unit got %b exp 0", stall1); end
    tests++; if (busy_mask1 !== 32'h400) begin fails++; $display("FAIL stray_wb_keeps_x10 got %h exp 00000400", busy_mask1); end
    tests++; if (stall_count2 !== 2'd3) begin fails++; $display("FAIL count_hold_sat got %0d exp 3", stall_count2); end
    idle();
  endtask

  // x0 as source or destination never creates a hazard.
  task automatic test_x0();
    do_reset();
    set_op(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 3'd2);
    #1;
    tests++; if (stall1 !== 1'b0) begin fails++; $display("FAIL x0_stall got %b exp 0", stall1); end
    tick();
    tests++; if (busy_mask1 !== 32'h0) begin fails++; $display("FAIL x0_busy got %h exp 0", busy_mask1); end
    #1;
    tests++; if (stall1 !== 1'b0) begin fails++; $display("FAIL x0_again_stall got %b exp 0", stall1); end
    idle();
  endtask

  // Flush suppresses stall and scoreboard load; reset clears pending state at once.
  task automatic test_flush_reset();
    do_reset();
    set_op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd2);
    tick();
    set_op(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 3'd3);
    flush = 1'b1;
    #1;
    tests++; if (stall1 !== 1'b0) begin fails++; $display("FAIL flush_stall got %b exp 0", stall1); end
    tests++; if (pc_write1 !== 1'b1) begin fails++; $display("FAIL flush_pc_write got %b exp 1", pc_write1); end
    tick();
    tests++; if (busy_mask1 !== 32'h20) begin fails++; $display("FAIL flush_no_load got %h exp 00000020", busy_mask1); end
    tests++; if (stall_count1 !== 32'd0) begin fails++; $display("FAIL flush_count got %0d exp 0", stall_count1); end
    flush = 1'b0;
    #1;
    tests++; if (stall1 !== 1'b1) begin fails++; $display("FAIL post_flush_stall got %b exp 1", stall1); end
    rst_n = 1'b0;
    #1;
    tests++; if (busy_mask1 !== 32'h0) begin fails++; $display("FAIL async_reset_busy got %h exp 0", busy_mask1); end
    tests++; if (stall1 !== 1'b0) begin fails++; $display("FAIL async_reset_stall got %b exp 0", stall1); end
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_alu_forward();
    test_long_unit();
    test_x0();
    test_flush_reset();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
